// File: rtl/sequenciador_camadas.sv
// Layer sequencer: steps an inference through up to MAX_CAMADAS layers using a
// small per-layer config table, a start/wait/capture handshake with the layer
// unit, and a per-layer wait timeout that drops into a sticky error.
module sequenciador_camadas #(
    parameter int unsigned MAX_CAMADAS = 4,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        iRst_n,
    input  logic        iStart,
    input  logic [2:0]  iNumCamadas,
    input  logic        iCfgWe,
    input  logic [1:0]  iCfgAddr,
    input  logic [4:0]  iCfgQtdEntradas,
    input  logic [4:0]  iCfgQtdNeuronios,
    input  logic [1:0]  iCfgCtrlFA,
    input  logic        iCfgBias,
    input  logic        iFlagCamada,
    output logic        oStartNeuro,
    output logic        oStartCamada,
    output logic [19:0] oEn,
    output logic        oFlagBias,
    output logic [1:0]  oCtrlFA,
    output logic [4:0]  oQtdEntradas,
    output logic        oSelRealim,
    output logic        oLatchSaida,
    output logic [1:0]  oCamadaAtual,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErro
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StConfig, StStart, StWait, StCapture, StDone, StErro
    } state_e;

    state_e          st_q, st_d;
    logic [1:0]      layer_q, layer_d;
    logic [2:0]      num_q, num_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            erro_q, erro_d;
    logic            busy_q, start_neuro_q, start_camada_q, latch_q, done_q;

    logic [4:0]      tab_ent_q [MAX_CAMADAS];
    logic [4:0]      tab_neu_q [MAX_CAMADAS];
    logic [1:0]      tab_fa_q  [MAX_CAMADAS];
    logic            tab_bias_q[MAX_CAMADAS];

    logic [4:0]      neu_atual;
    logic            neu_invalido;
    logic            num_valido;
    logic            cfg_addr_ok;

    assign neu_atual    = tab_neu_q[layer_q];
    assign neu_invalido = (neu_atual == 5'd0) || (neu_atual > 5'd20);
    assign num_valido   = (iNumCamadas != 3'd0) && (32'(iNumCamadas) <= MAX_CAMADAS);
    assign cfg_addr_ok  = 32'(iCfgAddr) < MAX_CAMADAS;

    // Next-state logic for the sequencer and its layer/timeout bookkeeping.
    always_comb begin
        st_d    = st_q;
        layer_d = layer_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        erro_d  = erro_q;
        unique case (st_q)
            StIdle: begin
                if (iStart) begin
                    if (num_valido) begin
                        st_d    = StConfig;
                        layer_d = 2'd0;
                        num_d   = iNumCamadas;
                        erro_d  = 1'b0;
                    end else begin
                        st_d = StErro;
                    end
                end
            end
            StConfig:  st_d = neu_invalido ? StErro : StStart;
            StStart: begin
                cnt_d = '0;
                st_d  = StWait;
            end
            StWait: begin
                // The layer flag takes priority over an expiring timeout.
                if (iFlagCamada) begin
                    st_d = StCapture;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    st_d = StErro;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                if ({1'b0, layer_q} == num_q - 3'd1) begin
                    st_d = StDone;
                end else begin
                    layer_d = layer_q + 2'd1;
                    st_d    = StConfig;
                end
            end
            StDone, StErro: begin
                st_d    = StIdle;
                layer_d = 2'd0;
            end
            default: st_d = StIdle;
        endcase
        if (st_d == StErro) erro_d = 1'b1;
    end

    // State, registered control outputs and the config table.
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            st_q           <= StIdle;
            layer_q        <= 2'd0;
            num_q          <= 3'd0;
            cnt_q          <= '0;
            erro_q         <= 1'b0;
            busy_q         <= 1'b0;
            start_neuro_q  <= 1'b0;
            start_camada_q <= 1'b0;
            latch_q        <= 1'b0;
            done_q         <= 1'b0;
            for (int i = 0; i < int'(MAX_CAMADAS); i++) begin
                tab_ent_q[i]  <= 5'd0;
                tab_neu_q[i]  <= 5'd0;
                tab_fa_q[i]   <= 2'd0;
                tab_bias_q[i] <= 1'b0;
            end
        end else begin
            st_q           <= st_d;
            layer_q        <= layer_d;
            num_q          <= num_d;
            cnt_q          <= cnt_d;
            erro_q         <= erro_d;
            busy_q         <= (st_d == StConfig) || (st_d == StStart) ||
                              (st_d == StWait) || (st_d == StCapture);
            start_neuro_q  <= (st_d == StStart);
            start_camada_q <= (st_d == StWait) || (st_d == StCapture);
            latch_q        <= (st_d == StCapture);
            done_q         <= (st_d == StDone);
            // Table is frozen while an inference is in flight.
            if (st_q == StIdle && iCfgWe && cfg_addr_ok) begin
                tab_ent_q[iCfgAddr]  <= iCfgQtdEntradas;
                tab_neu_q[iCfgAddr]  <= iCfgQtdNeuronios;
                tab_fa_q[iCfgAddr]   <= iCfgCtrlFA;
                tab_bias_q[iCfgAddr] <= iCfgBias;
            end
        end
    end

    // Neuron enables: first QtdNeuronios bits while the layer is started/running.
    always_comb begin
        oEn = '0;
        if (st_q == StStart || st_q == StWait) begin
            for (int k = 0; k < 20; k++) begin
                oEn[k] = (5'(k) < neu_atual);
            end
        end
    end

    assign oQtdEntradas = busy_q ? tab_ent_q[layer_q]  : 5'd0;
    assign oCtrlFA      = busy_q ? tab_fa_q[layer_q]   : 2'd0;
    assign oFlagBias    = busy_q ? tab_bias_q[layer_q] : 1'b0;
    assign oStartNeuro  = start_neuro_q;
    assign oStartCamada = start_camada_q;
    assign oLatchSaida  = latch_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oErro        = erro_q;
    assign oCamadaAtual = layer_q;
    assign oSelRealim   = (layer_q != 2'd0);

endmodule
